ring_counter4: RTL and testbench
================================

// Module: ring_counter4
// PURPOSE
//   4-stage one-hot ring counter producing four mutually exclusive timing phases t0..t3.
//   Provides a timing-phase generator: each phase is high for exactly one clock cycle, in rotation.
//   Free-running after reset. No enable input and no load input.
// PARAMETERS
//   INIT_STATE  4'b0001  one-hot value loaded on reset, bit i drives ti; must have exactly one bit set
//   DIR         0        0: token moves t0->t1->t2->t3->t0; 1: token moves t0->t3->t2->t1->t0
// PORTS
//   clk  input   1  clock; all state changes on the rising edge
//   rst  input   1  reset, synchronous, active-high
//   t0   input?  -- no: t0  output  1  phase 0, high while the token is in stage 0
//   t1   output  1  phase 1
//   t2   output  1  phase 2
//   t3   output  1  phase 3
//   One clock. Reset is synchronous and active-high.
// BEHAVIOUR
//   - State: 4-bit register q. Outputs are driven directly from the flops: {t3,t2,t1,t0} = q.
//     There is no combinational path from any input to any output.
//   - Reset: at a rising clk edge with rst=1, q <= INIT_STATE. With defaults, t0=1 and t1=t2=t3=0.
//     rst has priority over counting. Asserting rst mid-sequence reloads INIT_STATE on the next edge.
//   - Count with DIR=0: at each rising edge with rst=0, q <= {q[2:0], q[3]} (rotate left).
//     Wrap-around: t3 returns to t0.
//   - Count with DIR=1: at each rising edge with rst=0, q <= {q[0], q[3:1]} (rotate right).
//   - Period is 4 cycles. Each output is high for 1 cycle in every 4.
//     In a legal state exactly one output is high.
//   - Latency: the first non-reset edge after rst is released advances the token one stage.
//   - Before the first reset edge, the outputs are unspecified. The bench must not check them.
//   - Illegal states (zero bits or more than one bit set) are unreachable from reset.
//     Handling of illegal states is defined under CONFIGURATION.
// CONFIGURATION
//   RING_COUNTER_SELF_CORRECT_EN
//     defined:
//       - A one-hot check is computed on q.
//       - If q is not one-hot at a rising edge with rst=0, then q <= INIT_STATE instead of rotating.
//       - Recovery therefore takes at most 1 cycle.
//     undefined:
//       - Pure rotation. An illegal pattern circulates unchanged in shape.
//       - No check logic is synthesized.
// STRUCTURE
//   - Shared package ring_counter_pkg holds:
//       - localparam RING_W = 4
//       - localparam RING_INIT_DEFAULT = 4'b0001
//       - function is_onehot(input [RING_W-1:0] v), which returns 1 iff exactly one bit is set
//   - One natural sub-module: onehot_check (input [3:0] v, output ok).
//     Instantiate it only under RING_COUNTER_SELF_CORRECT_EN.
//   - Keep the rest flat: one always @(posedge clk) block for q, and continuous assigns for t0..t3.
// TESTING
//   - Clock period 20 ns. Hold rst=1 for 100 ns, then rst=0 -> {t3,t2,t1,t0} reads
//     0001 during reset, then 0010, 0100, 1000, 0001 on successive edges.
//   - Run 1000 ns free -> every cycle exactly one output is high. Each ti is high once every 4 cycles.
//     There are no glitches between edges.
//   - Assert rst=1 for one cycle while state=0100 -> next edge gives 0001.
//     The sequence then resumes 0010 from the following edge.
//   - DIR=1 build, release reset -> sequence 0001, 1000, 0100, 0010, 0001.
//   - Macro defined: force q=4'b0110 and release with rst=0 -> next edge gives 0001.
//     Macro undefined: the same force gives 1100 (rotated).
//   - INIT_STATE=4'b0100, rst pulse -> 0100 after reset, then 1000, 0001.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the ring counter.
// Used by ring_counter4 and onehot_check.
package ring_counter_pkg;

  localparam int RING_W = 4;
  localparam logic [RING_W-1:0] RING_INIT_DEFAULT = 4'b0001;

  function automatic logic is_onehot(input logic [RING_W-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/ring_counter4_onehot_check.sv
// One-hot detector for the ring counter state.
// Instantiated only when RING_COUNTER_SELF_CORRECT_EN is defined.
module onehot_check
  import ring_counter_pkg::*;
(
  input  logic [3:0] v,
  output logic       ok
);

  assign ok = is_onehot(v);

endmodule

// File: rtl/ring_counter4.sv
// 4-stage one-hot ring counter driving phases t0..t3.
// Define RING_COUNTER_SELF_CORRECT_EN to reload INIT_STATE on illegal states.
module ring_counter4
  import ring_counter_pkg::*;
#(
  parameter logic [RING_W-1:0] INIT_STATE = RING_INIT_DEFAULT,
  parameter bit                DIR        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic t0,
  output logic t1,
  output logic t2,
  output logic t3
);

  logic [RING_W-1:0] q;
  logic [RING_W-1:0] rot;

  assign rot = DIR ? {q[0], q[3:1]} : {q[2:0], q[3]};

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic ok;

  onehot_check u_chk (
    .v  (q),
    .ok (ok)
  );

  // token register: reset, recover from illegal state, else rotate
  always_ff @(posedge clk) begin
    if (rst)      q <= INIT_STATE;
    else if (!ok) q <= INIT_STATE;
    else          q <= rot;
  end
`else
  // token register: reset or rotate
  always_ff @(posedge clk) begin
    if (rst) q <= INIT_STATE;
    else     q <= rot;
  end
`endif

  assign t0 = q[0];
  assign t1 = q[1];
  assign t2 = q[2];
  assign t3 = q[3];

endmodule

// File: tb/tb_ring_counter4.sv
// Scoreboard bench for ring_counter4: default, reversed and alt-init builds.
// Expectations are queued per cycle and popped by a negedge monitor.
module tb_ring_counter4;

  logic clk;
  logic rst;
  logic d0, d1, d2, d3;
  logic r0, r1, r2, r3;
  logic i0, i1, i2, i3;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] r;
    logic [3:0] i;
    bit         c;
    bit         k;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt[4] = '{0, 0, 0, 0};

  logic [3:0] md, mr, mi;

  ring_counter4 dut (
    .clk (clk), .rst (rst),
    .t0 (d0), .t1 (d1), .t2 (d2), .t3 (d3)
  );

  ring_counter4 #(.DIR(1'b1)) dut_r (
    .clk (clk), .rst (rst),
    .t0 (r0), .t1 (r1), .t2 (r2), .t3 (r3)
  );

  ring_counter4 #(.INIT_STATE(4'b0100)) dut_i (
    .clk (clk), .rst (rst),
    .t0 (i0), .t1 (i1), .t2 (i2), .t3 (i3)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] rr(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  task automatic cmp(input string n, input logic [3:0] a,
                     input logic [3:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic cmpi(input string n, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  // monitor: pop the expectation for this cycle and compare
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] vd;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      vd = {d3, d2, d1, d0};
      cmp("dir0", vd, e.d);
      cmp("dir1", {r3, r2, r1, r0}, e.r);
      cmp("init0100", {i3, i2, i1, i0}, e.i);
      if (e.c) begin
        cmpi("onehot", $countones(vd), 1);
        for (int b = 0; b < 4; b++)
          if (vd[b]) cnt[b]++;
      end
      if (e.k) begin
        for (int b = 0; b < 4; b++) begin
          cmpi($sformatf("period_t%0d", b), cnt[b], 12);
          cnt[b] = 0;
        end
      end
    end
  end

  task automatic step(input logic [3:0] d, input logic [3:0] r,
                      input logic [3:0] i, input bit c = 0,
                      input bit k = 0);
    @(posedge clk);
    #1;
    sb.push_back('{d: d, r: r, i: i, c: c, k: k});
  endtask

  task automatic adv(input bit c = 0, input bit k = 0);
    md = rl(md);
    mr = rr(mr);
    mi = rl(mi);
    step(md, mr, mi, c, k);
  endtask

  initial begin
    rst = 1'b1;
    md  = 4'b0001;
    mr  = 4'b0001;
    mi  = 4'b0100;
    for (int n = 0; n < 5; n++)
      step(4'b0001, 4'b0001, 4'b0100);
    rst = 1'b0;

    step(4'b0010, 4'b1000, 4'b1000);
    step(4'b0100, 4'b0100, 4'b0001);
    step(4'b1000, 4'b0010, 4'b0010);
    step(4'b0001, 4'b0001, 4'b0100);

    for (int n = 0; n < 48; n++)
      adv(1'b1, 1'b0);
    adv(1'b0, 1'b1);

    for (int n = 0; n < 4 && md != 4'b0100; n++)
      adv();
    rst = 1'b1;
    step(4'b0001, 4'b0001, 4'b0100);
    rst = 1'b0;
    md = 4'b0001;
    mr = 4'b0001;
    mi = 4'b0100;
    step(4'b0010, 4'b1000, 4'b1000);
    md = 4'b0010;
    mr = 4'b1000;
    mi = 4'b1000;
    adv();

    @(negedge clk);
    #1;
    force dut.q = 4'b0110;
    #1;
    release dut.q;
    mr = rr(mr);
    mi = rl(mi);
`ifdef RING_COUNTER_SELF_CORRECT_EN
    md = 4'b0001;
    step(md, mr, mi);
    adv();
    adv();
`else
    md = 4'b1100;
    step(md, mr, mi);
    adv();
    adv();
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
